uart_codec_sequencer: RTL and testbench

UART_CODEC_SEQUENCER -- requirements
Module: uart_codec_sequencer

---
 rtl/uart_codec_sequencer_if.sv | 25 ++
 rtl/uart_codec_sequencer.sv | 138 +++++++++++++
 tb/tb_uart_codec_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_codec_sequencer_if.sv
// Handshake bundle between the UART buffer, nibble codec and transmitter and the sequencer.
interface uart_codec_sequencer_if;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic [3:0] nibble_out;
  logic       enc_active;
  logic       dec_valid;
  logic [3:0] dec_nibble;
  logic [7:0] tx_byte;
  logic       tx_enable;
  logic       tx_busy;
  logic       busy;
  logic [7:0] drop_cnt;
  logic       err_timeout;

  modport master (
    output byte_in, byte_valid, dec_valid, dec_nibble, tx_busy,
    input  nibble_out, enc_active, tx_byte, tx_enable, busy, drop_cnt, err_timeout
  );

  modport slave (
    input  byte_in, byte_valid, dec_valid, dec_nibble, tx_busy,
    output nibble_out, enc_active, tx_byte, tx_enable, busy, drop_cnt, err_timeout
  );
endinterface

// File: rtl/uart_codec_sequencer.sv
// Splits each received byte into two nibbles, runs each through the encoder/decoder pair,
// reassembles the corrected byte and launches it to the transmitter; one byte can queue.
module uart_codec_sequencer #(
  parameter int unsigned ACTIVE_CYCLES = 3,
  parameter int unsigned TIMEOUT       = 15
) (
  input logic                   clk,
  input logic                   reset,
  uart_codec_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StEncLo, StWaitLo, StEncHi, StWaitHi, StTxWait, StTxGo
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] work_q, work_d;
  logic [7:0] result_q, result_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] pend_q, pend_d;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] drop_q, drop_d;
  logic       err_q, err_d;
  logic       timeout_hit;
  logic       consume, direct;

  localparam logic [7:0] ActLast  = 8'(ACTIVE_CYCLES - 1);
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    result_d    = result_q;
    tx_d        = tx_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A queued byte always goes ahead of a new arrival.
        if (pend_valid_q) begin
          work_d  = pend_q;
          state_d = StEncLo;
        end else if (bus.byte_valid) begin
          work_d  = bus.byte_in;
          state_d = StEncLo;
        end
      end
      StEncLo: if (cnt_q == ActLast) state_d = StWaitLo;
      StWaitLo: begin
        if (bus.dec_valid) begin
          result_d[3:0] = bus.dec_nibble;
          state_d       = StEncHi;
        end else if (cnt_q == WaitLast) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
        end
      end
      StEncHi: if (cnt_q == ActLast) state_d = StWaitHi;
      StWaitHi: begin
        if (bus.dec_valid) begin
          result_d[7:4] = bus.dec_nibble;
          state_d       = StTxWait;
        end else if (cnt_q == WaitLast) begin
          timeout_hit = 1'b1;
          state_d     = StIdle;
        end
      end
      StTxWait: begin
        if (!bus.tx_busy) begin
          tx_d    = result_q;
          state_d = StTxGo;
        end
      end
      StTxGo:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The phase counter restarts on every state change and only runs in ENC/WAIT states.
    cnt_d = cnt_q + 8'd1;
    if (state_d != state_q || state_q == StIdle || state_q == StTxWait || state_q == StTxGo) begin
      cnt_d = '0;
    end
    err_d = err_q | timeout_hit;
  end

  always_comb begin
    consume      = (state_q == StIdle) && pend_valid_q;
    direct       = (state_q == StIdle) && !pend_valid_q && bus.byte_valid;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q & ~consume;
    drop_d       = drop_q;
    if (bus.byte_valid && !direct) begin
      if (!pend_valid_d) begin
        pend_valid_d = 1'b1;
        pend_d       = bus.byte_in;
      end else if (drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      work_q       <= '0;
      result_q     <= '0;
      tx_q         <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      drop_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      work_q       <= work_d;
      result_q     <= result_d;
      tx_q         <= tx_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      drop_q       <= drop_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    bus.nibble_out = (state_q == StIdle || state_q == StEncLo || state_q == StWaitLo) ?
                     work_q[3:0] : work_q[7:4];
    bus.enc_active = (state_q == StEncLo) || (state_q == StEncHi);
    bus.tx_enable  = (state_q == StTxGo);
    bus.tx_byte    = tx_q;
    bus.busy       = (state_q != StIdle) || pend_valid_q;
    bus.drop_cnt   = drop_q;
    // Flag is visible in the very cycle the wait limit is reached.
    bus.err_timeout = err_q | timeout_hit;
  end

endmodule

// File: tb/tb_uart_codec_sequencer.sv
// Directed bench: loopback decoder, queueing/drop, tx back-pressure, timeout, mid-flight reset.
module tb_uart_codec_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  bit   dec_en = 1'b1;
  logic [7:0] txq[$];

  uart_codec_sequencer_if bus ();

  uart_codec_sequencer #(.ACTIVE_CYCLES(3), .TIMEOUT(15)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Loopback decoder: returns the last encoded nibble in the first cycle enc_active is low.
  initial begin
    logic       was_act;
    logic [3:0] last_nib;
    was_act = 1'b0;
    last_nib = '0;
    bus.dec_valid  = 1'b0;
    bus.dec_nibble = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dec_en && was_act && !bus.enc_active) begin
        bus.dec_valid  = 1'b1;
        bus.dec_nibble = last_nib;
      end else begin
        bus.dec_valid  = 1'b0;
      end
      was_act = bus.enc_active;
      if (bus.enc_active) last_nib = bus.nibble_out;
    end
  end

  always @(negedge clk) if (bus.tx_enable) txq.push_back(bus.tx_byte);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lo_cnt, hi_cnt, en_cnt, reached, stayed;
    logic [3:0] first_nib;
    bit got_first;

    rst_n = 1'b0;
    bus.byte_in = '0;
    bus.byte_valid = 1'b0;
    bus.tx_busy = 1'b0;
    look();
    check("rst_nibble", 32'(bus.nibble_out), 32'h0);
    check("rst_enc", 32'(bus.enc_active), 32'h0);
    check("rst_txen", 32'(bus.tx_enable), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_drop", 32'(bus.drop_cnt), 32'h0);
    check("rst_err", 32'(bus.err_timeout), 32'h0);
    check("rst_txbyte", 32'(bus.tx_byte), 32'h0);
    rst_n = 1'b1;
    look();

    // Single byte 0x96 with loopback decoder; byte_valid cycle counts as cycle 1.
    txq.delete();
    lat = 0; lo_cnt = 0; hi_cnt = 0; got_first = 0; first_nib = '0;
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'h96;
    look();
    for (int cyc = 2; cyc <= 16; cyc++) begin
      tick(); bus.byte_valid = 1'b0;
      look();
      if (bus.enc_active) begin
        if (!got_first) begin first_nib = bus.nibble_out; got_first = 1; end
        if (bus.nibble_out == 4'h6) lo_cnt++;
        else if (bus.nibble_out == 4'h9) hi_cnt++;
      end
      if (bus.tx_enable && lat == 0) lat = cyc;
    end
    check("t1_first_nibble", 32'(first_nib), 32'h6);
    check("t1_lo_active", 32'(lo_cnt), 32'd3);
    check("t1_hi_active", 32'(hi_cnt), 32'd3);
    check("t1_latency", 32'(lat), 32'd11);
    check("t1_tx_count", 32'(txq.size()), 32'd1);
    check("t1_tx_byte", (txq.size() > 0) ? 32'(txq[0]) : 32'hdead, 32'h96);

    // 0xA5, then 0x3C two cycles later (queued), then 0xFF while both held (dropped).
    txq.delete();
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'hA5; look();
    tick(); bus.byte_valid = 1'b0; look();
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'h3C; look();
    tick(); bus.byte_in = 8'hFF; look();
    for (int i = 0; i < 40; i++) begin
      tick(); bus.byte_valid = 1'b0; look();
    end
    check("t2_tx_count", 32'(txq.size()), 32'd2);
    check("t2_tx0", (txq.size() > 0) ? 32'(txq[0]) : 32'hdead, 32'hA5);
    check("t2_tx1", (txq.size() > 1) ? 32'(txq[1]) : 32'hdead, 32'h3C);
    check("t2_drop", 32'(bus.drop_cnt), 32'd1);
    check("t2_idle", 32'(bus.busy), 32'h0);

    // Transmitter busy for 20 cycles once the result is ready.
    txq.delete();
    bus.tx_busy = 1'b1;
    reached = 0;
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'h5A; look();
    for (int i = 0; i < 30 && reached == 0; i++) begin
      tick(); bus.byte_valid = 1'b0; look();
      if (3'(dut.state_q) == 3'd5) reached = 1;
    end
    check("t3_reach_txwait", 32'(reached), 32'd1);
    stayed = 1; en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(); look();
      if (3'(dut.state_q) != 3'd5) stayed = 0;
      if (bus.tx_enable) en_cnt++;
    end
    check("t3_stay_txwait", 32'(stayed), 32'd1);
    check("t3_no_early_txen", 32'(en_cnt), 32'd0);
    tick(); bus.tx_busy = 1'b0; look();
    check("t3_txen_same_cycle", 32'(bus.tx_enable), 32'h0);
    tick(); look();
    check("t3_txen_next_cycle", 32'(bus.tx_enable), 32'h1);
    check("t3_tx_byte", 32'(bus.tx_byte), 32'h5A);
    tick(); look();
    check("t3_txen_single", 32'(bus.tx_enable), 32'h0);
    check("t3_tx_count", 32'(txq.size()), 32'd1);
    check("t3_tx_hold", 32'(bus.tx_byte), 32'h5A);

    // Silent decoder: timeout in the 15th WAIT_LO cycle (cycles 5..19).
    txq.delete();
    dec_en = 1'b0;
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'h3C; look();
    for (int cyc = 2; cyc <= 20; cyc++) begin
      tick(); bus.byte_valid = 1'b0; look();
      if (cyc == 18) check("t4_err_before", 32'(bus.err_timeout), 32'h0);
      if (cyc == 19) check("t4_err_at_15", 32'(bus.err_timeout), 32'h1);
      if (cyc == 20) check("t4_back_idle", 32'(bus.busy), 32'h0);
    end
    check("t4_no_tx", 32'(txq.size()), 32'd0);
    dec_en = 1'b1;
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'hC3; look();
    for (int i = 0; i < 15; i++) begin
      tick(); bus.byte_valid = 1'b0; look();
    end
    check("t4_next_byte", (txq.size() == 1) ? 32'(txq[0]) : 32'hdead, 32'hC3);
    check("t4_err_sticky", 32'(bus.err_timeout), 32'h1);

    // Reset pulsed during ENC_HI with a byte queued.
    txq.delete();
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'h96; look();
    tick(); bus.byte_valid = 1'b0; look();
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'h44; look();
    tick(); bus.byte_valid = 1'b0; look();
    tick(); look();
    tick(); look();
    check("t5_in_enc_hi", {27'd0, bus.enc_active, bus.nibble_out}, {27'd0, 1'b1, 4'h9});
    tick(); rst_n = 1'b0; #1;
    check("t5_nibble", 32'(bus.nibble_out), 32'h0);
    check("t5_enc", 32'(bus.enc_active), 32'h0);
    check("t5_busy", 32'(bus.busy), 32'h0);
    check("t5_txbyte", 32'(bus.tx_byte), 32'h0);
    check("t5_err", 32'(bus.err_timeout), 32'h0);
    check("t5_txen", 32'(bus.tx_enable), 32'h0);
    look(); rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin tick(); look(); end
    check("t5_no_tx_after", 32'(txq.size()), 32'd0);
    tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'h81; look();
    for (int i = 0; i < 15; i++) begin
      tick(); bus.byte_valid = 1'b0; look();
    end
    check("t5_resume", (txq.size() == 1) ? 32'(txq[0]) : 32'hdead, 32'h81);

    // 302 back-to-back bytes under tx back-pressure: 2 held, 300 dropped.
    bus.tx_busy = 1'b1;
    for (int i = 0; i < 302; i++) begin
      tick(); bus.byte_valid = 1'b1; bus.byte_in = 8'h77; look();
      if (i == 100) check("t6_drop_mid", 32'(bus.drop_cnt), 32'd98);
    end
    tick(); bus.byte_valid = 1'b0; look();
    check("t6_drop_sat", 32'(bus.drop_cnt), 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
